// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
//
// Each accepted instruction is classified from opcode/funct3, turned into an
// immediate select code and a full XLEN-bit immediate, and written into a
// DEPTH-entry in-order FIFO. The FIFO output side is a valid/ready handshake.
//
// Optional feature macro: IMM_ILLEGAL_EN (adds illegal_o and per-entry flag).
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset, empties the FIFO
//   flush_i      synchronous flush, empties the FIFO (wins over push/pop)
//   in_valid_i   instr_i is valid
//   in_ready_o   FIFO has room (registered occupancy only)
//   instr_i      32-bit instruction word
//   out_valid_o  head entry valid
//   out_ready_i  consumer takes the head entry
//   imm_o        head immediate (zero when empty)
//   imm_sel_o    head select code (zero when empty)
//   illegal_o    head carries an unrecognised encoding (IMM_ILLEGAL_EN only)
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      imm_sel_o
`ifdef IMM_ILLEGAL_EN
   ,
   output logic            illegal_o
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Widen a 32-bit immediate to XLEN; zext selects zero fill over sign fill.
   function automatic logic [XLEN-1:0] extend(input logic [31:0] v, input logic zext);
      logic [XLEN-1:0] r;
      r       = {XLEN{~zext & v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   logic [4:0]  op;
   logic [2:0]  f3;
   logic [2:0]  sel_d;
   logic [31:0] imm32_d;
   logic        unused_opc_lsbs;

   assign op = instr_i[6:2];
   assign f3 = instr_i[14:12];
   // Low opcode bits are always 11 for 32-bit encodings and carry no format info.
   assign unused_opc_lsbs = ^instr_i[1:0];

`ifdef IMM_ILLEGAL_EN
   logic ill_d;
`endif

   always_comb begin
      sel_d   = 3'b000;
      imm32_d = {{20{instr_i[31]}}, instr_i[31:20]};
`ifdef IMM_ILLEGAL_EN
      ill_d   = 1'b0;
`endif
      case (op)
         5'b01100: begin
            imm32_d = '0;
         end
         5'b00100: begin
            if (f3 == 3'b011) sel_d = 3'b101;
         end
         5'b01000: begin
            sel_d   = 3'b001;
            imm32_d = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         5'b11000: begin
            // Unsigned-compare branches keep a signed offset; only the code differs.
            sel_d   = (f3[2:1] == 2'b11) ? 3'b111 : 3'b010;
            imm32_d = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
         end
         5'b01101, 5'b00101: begin
            sel_d   = 3'b100;
            imm32_d = {instr_i[31:12], 12'b0};
         end
         5'b11011: begin
            sel_d   = 3'b011;
            imm32_d = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};
         end
         5'b11001: begin
`ifdef IMM_ILLEGAL_EN
            ill_d = (f3 != 3'b000);
`endif
         end
         default: begin
            // Loads, and every unrecognised opcode, take the load decode.
            if (f3 == 3'b100 || f3 == 3'b101) sel_d = 3'b101;
`ifdef IMM_ILLEGAL_EN
            ill_d = (op != 5'b00000);
`endif
         end
      endcase
      if (sel_d == 3'b101) imm32_d = {20'b0, instr_i[31:20]};
   end

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   assign in_ready_o  = (count < CNT_FULL);
   assign out_valid_o = (count != '0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   // FIFO control state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   logic [XLEN-1:0] imm_mem [DEPTH];
   logic [2:0]      sel_mem [DEPTH];
`ifdef IMM_ILLEGAL_EN
   logic            ill_mem [DEPTH];
`endif

   // FIFO storage: data only, no reset; empty entries are masked at the output
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         imm_mem[wr_ptr] <= extend(imm32_d, sel_d == 3'b101);
         sel_mem[wr_ptr] <= sel_d;
`ifdef IMM_ILLEGAL_EN
         ill_mem[wr_ptr] <= ill_d;
`endif
      end
   end

   // Read mux; forcing zeros when empty gives reset-like outputs after reset/flush.
   assign imm_o     = out_valid_o ? imm_mem[rd_ptr] : '0;
   assign imm_sel_o = out_valid_o ? sel_mem[rd_ptr] : 3'b000;
`ifdef IMM_ILLEGAL_EN
   assign illegal_o = out_valid_o ? ill_mem[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instr;
   logic [31:0] imm;
   logic [2:0]  sel;
   logic        ill;

   logic        in_valid64, in_ready64, out_valid64, out_ready64;
   logic [31:0] instr64;
   logic [63:0] imm64;
   logic [2:0]  sel64;
   logic        ill64;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] imm;
      logic [2:0]  sel;
      logic        ill;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .imm_o(imm), .imm_sel_o(sel)
`ifdef IMM_ILLEGAL_EN
      , .illegal_o(ill)
`endif
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(3)) dut64 (
      .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
      .in_valid_i(in_valid64), .in_ready_o(in_ready64), .instr_i(instr64),
      .out_valid_o(out_valid64), .out_ready_i(out_ready64),
      .imm_o(imm64), .imm_sel_o(sel64)
`ifdef IMM_ILLEGAL_EN
      , .illegal_o(ill64)
`endif
   );

   // Hand-computed vectors: instruction, expected 32-bit immediate, code, illegal flag
   logic [31:0] t_instr [15] = '{32'hFFF04083, 32'h123450B7, 32'hFE20FEE3, 32'h00552623,
                                 32'hFE552E23, 32'h001000EF, 32'hFFFFF06F, 32'hFFF13093,
                                 32'h002081B3, 32'hFE000EE3, 32'h00001097, 32'hFFF100E7,
                                 32'h7FF0A083, 32'h8000D083, 32'h0000007F};
   logic [31:0] t_imm   [15] = '{32'h00000FFF, 32'h12345000, 32'hFFFFFFFC, 32'h0000000C,
                                 32'hFFFFFFFC, 32'h00000800, 32'hFFFFFFFE, 32'h00000FFF,
                                 32'h00000000, 32'hFFFFFFFC, 32'h00001000, 32'hFFFFFFFF,
                                 32'h000007FF, 32'h00000800, 32'h00000000};
   logic [2:0]  t_sel   [15] = '{3'd5, 3'd4, 3'd7, 3'd1, 3'd1, 3'd3, 3'd3, 3'd5,
                                 3'd0, 3'd2, 3'd4, 3'd0, 3'd0, 3'd5, 3'd0};
   logic        t_ill   [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] e_imm,
                        input logic [2:0] e_sel, input logic e_ill);
      exp_t e;
      in_valid = 1'b1;
      instr    = ins;
      e.imm = e_imm; e.sel = e_sel; e.ill = e_ill;
      sb.push_back(e);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  {63'b0, in_ready},  64'd1);
      chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
      chk({tag, "_imm"},       {32'b0, imm},       64'd0);
      chk({tag, "_sel"},       {61'b0, sel},       64'd0);
`ifdef IMM_ILLEGAL_EN
      chk({tag, "_illegal"},   {63'b0, ill},       64'd0);
`endif
   endtask

   // Scoreboard: every pop the DUT will take at the next edge is compared in order
   always @(negedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_pop", {63'b0, out_valid}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_imm", {32'b0, imm}, {32'b0, e.imm});
            chk("sb_sel", {61'b0, sel}, {61'b0, e.sel});
`ifdef IMM_ILLEGAL_EN
            chk("sb_illegal", {63'b0, ill}, {63'b0, e.ill});
`endif
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
      in_valid64 = 1'b0; instr64 = '0; out_ready64 = 1'b0;
      #2;
      chk_reset_outputs("reset");
      step(); step();
      rst = 1'b0;

      // Single ADDI: invisible before the edge, visible one cycle after
      out_ready = 1'b1;
      drive(32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0);
      #1 chk("no_bypass", {63'b0, out_valid}, 64'd0);
      step();
      in_valid = 1'b0;
      chk("addi_valid", {63'b0, out_valid}, 64'd1);
      chk("addi_imm", {32'b0, imm}, 64'hFFFFFFFF);
      step();
      chk("addi_drained", {63'b0, out_valid}, 64'd0);

      // Back-to-back stream with continuous ready
      for (int i = 0; i < 15; i++) begin
         drive(t_instr[i], t_imm[i], t_sel[i], t_ill[i]);
         step();
         chk($sformatf("b2b_valid_%0d", i), {63'b0, out_valid}, 64'd1);
      end
      in_valid = 1'b0;
      step();
      chk("b2b_drained", {63'b0, out_valid}, 64'd0);

      // Fill DEPTH=2, hold the third push, drain in order
      out_ready = 1'b0;
      drive(32'h7FF0A083, 32'h000007FF, 3'd0, 1'b0);
      step();
      chk("fill1_ready", {63'b0, in_ready}, 64'd1);
      drive(32'h00552623, 32'h0000000C, 3'd1, 1'b0);
      step();
      chk("fill2_ready", {63'b0, in_ready}, 64'd0);
      drive(32'h001000EF, 32'h00000800, 3'd3, 1'b0);
      step();
      chk("held_ready", {63'b0, in_ready}, 64'd0);
      chk("held_head_imm", {32'b0, imm}, 64'h7FF);
      out_ready = 1'b1;
      #1 chk("full_no_passthru", {63'b0, in_ready}, 64'd0);
      step();
      chk("after_pop_ready", {63'b0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      chk("third_present", {63'b0, out_valid}, 64'd1);
      step();
      chk("full_drained", {63'b0, out_valid}, 64'd0);

      // Flush while full, with a push request
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'hFFF00093;
      step();
      instr = 32'h123450B7;
      step();
      flush = 1'b1; instr = 32'h00552623;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk_reset_outputs("flush_full");

      // Flush with one entry and a push that can be accepted
      in_valid = 1'b1; instr = 32'hFFF00093;
      step();
      flush = 1'b1; instr = 32'h123450B7;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_push_valid", {63'b0, out_valid}, 64'd0);
      chk("flush_push_ready", {63'b0, in_ready}, 64'd1);
      out_ready = 1'b1;
      drive(32'h00001097, 32'h00001000, 3'd4, 1'b0);
      step();
      in_valid = 1'b0;
      chk("post_flush_imm", {32'b0, imm}, 64'h1000);
      step();

      // Asynchronous reset mid-burst
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'h001000EF;
      step();
      instr = 32'hFE000EE3;
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset_outputs("async_rst");
      #2 rst = 1'b0;
      step();
      out_ready = 1'b1;
      drive(32'hFE552E23, 32'hFFFFFFFC, 3'd1, 1'b0);
      step();
      in_valid = 1'b0;
      chk("post_rst_imm", {32'b0, imm}, 64'hFFFFFFFC);
      chk("post_rst_sel", {61'b0, sel}, 64'd1);
      step();

      // XLEN=64, DEPTH=3 instance: extension rules, full flag, pointer wrap
      in_valid64 = 1'b1; instr64 = 32'h800000B7;
      step();
      instr64 = 32'hFFF00093;
      step();
      chk("x64_ready_2", {63'b0, in_ready64}, 64'd1);
      instr64 = 32'hFFF04083;
      step();
      in_valid64 = 1'b0;
      chk("x64_ready_3", {63'b0, in_ready64}, 64'd0);
      chk("x64_lui_imm", imm64, 64'hFFFFFFFF80000000);
      chk("x64_lui_sel", {61'b0, sel64}, 64'd4);
      out_ready64 = 1'b1;
      step();
      chk("x64_addi_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
      step();
      chk("x64_lbu_imm", imm64, 64'h0000000000000FFF);
      chk("x64_lbu_sel", {61'b0, sel64}, 64'd5);
      step();
      chk("x64_empty", {63'b0, out_valid64}, 64'd0);
      in_valid64 = 1'b1; instr64 = 32'hFFFFF06F;
      step();
      in_valid64 = 1'b0;
      chk("x64_wrap_jal_imm", imm64, 64'hFFFFFFFFFFFFFFFE);
      chk("x64_wrap_jal_sel", {61'b0, sel64}, 64'd3);
      step();
      chk("x64_drained", {63'b0, out_valid64}, 64'd0);

      for (int k = 0; k < 20 && sb.size() != 0; k++) step();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
